mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-addressed synchronous memory that answers processor data-register traffic: the responder end of the DR load/store path.
- Accepts a single-cycle request carrying address, write-enable and write data. Waits a programmable number of cycles, then performs the access and pulses ack.
- On reads, returns the word on data_out; the DR captures it with its ld input on the ack cycle.

Parameters:
- P, 15, MSB index of data word (word width P+1)
- A, 7, MSB index of address (depth 2^(A+1) words)
- LAT, 2, extra wait cycles before the access is performed (0..15)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req  input  1  request strobe, sampled only in IDLE
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  A+1  word address; sampled with req
- data_in  input  P+1  write data; sampled with req
- data_out  output  P+1  read data, registered
- ack  output  1  one-cycle completion pulse, registered
- busy  output  1  high while a request is in progress (WAIT or DONE)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, sampled on a clk edge with rst=1, forces the following regardless of state:
  - state=IDLE, ack=0, busy=0, data_out=0, wait counter=0.
  - Memory array contents are not cleared by reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with req=1: latch we/addr/data_in into internal registers, load counter=LAT, set busy=1, go to WAIT.
  - req=0: stay in IDLE.
- WAIT:
  - Counter nonzero: decrement it and stay in WAIT.
  - Counter zero: perform the access on this edge and go to DONE.
    - Write: mem[addr_l] <= data_l.
    - Read: data_out <= mem[addr_l].
  - In both cases set ack=1 on the same edge.
- DONE: ack=1 for exactly one cycle; the next edge sets ack=0, busy=0 and returns to IDLE.
- Latency:
  - Request sampled at edge k; ack is high in the cycle following edge k+LAT+1.
  - LAT=0 gives ack after edge k+1.
  - Minimum request spacing is LAT+3 edges (a req on the edge that leaves DONE is not accepted).
- req while busy=1 (WAIT or DONE) is ignored and not queued. The bench may raise req only when busy=0.
- Inputs we/addr/data_in may change freely after the sampling edge; the latched copies are used.
- data_out:
  - Updates only on read completion.
  - Holds its value through writes and idle cycles until the next read or reset.
- Read-after-write to the same address returns the newly written word (the write commits before the next request can be accepted).
- Reset mid-operation (WAIT or DONE) aborts the request. A write not yet committed (still in WAIT) is discarded; memory is unchanged.
- Address wraps naturally within 2^(A+1); no out-of-range condition exists.
- A write completion leaves data_out unchanged.

Test Plan:
1. Reset then idle: rst=1 one edge -> ack=0, busy=0, data_out=0; no ack for 10 idle cycles with req=0.
2. Write then read, LAT=2:
   - Write req at edge 0 with addr=0x05, data_in=0xBEEF, we=1 -> busy=1 after edge 0; ack=1 only in the cycle after edge 3; busy=0 after edge 4.
   - Then read addr=0x05 -> data_out=0xBEEF with ack, held afterwards.
3. Busy rejection: during WAIT of a read to 0x10, pulse req with we=1, addr=0x10, data_in=0x1234 -> ignored; exactly one ack; mem[0x10] unchanged (verified by a later read).
4. Reset mid-write: write req addr=0xFF data=0xAAAA, rst=1 on the next edge -> busy=0, no ack; a subsequent read of 0xFF returns the prior contents (0x0000 if preloaded so).
5. Address boundaries: write 0x1111 to addr 0x00 and 0x2222 to addr 0xFF, then read both -> 0x1111 and 0x2222; data_out unchanged across the intervening writes.
6. LAT=0 build: read request at edge k -> ack high after edge k+1, low after edge k+2; back-to-back requests accepted every 3 edges.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed synchronous memory acting as the responder
// end of the data-register load/store path. A single-cycle request is
// latched, held for LAT extra cycles, then the access is performed and ack
// is pulsed for one cycle. Read data is registered on data_out and held
// until the next read completes or reset.
module mem_responder #(
  parameter int P   = 15,
  parameter int A   = 7,
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [A:0] addr,
  input  logic [P:0] data_in,
  output logic [P:0] data_out,
  output logic       ack,
  output logic       busy
);

  localparam int DEPTH = 1 << (A + 1);

  // LAT is expected to lie in 0..15 so that it fits the 4-bit wait counter.
  localparam logic [3:0] LAT_LOAD = 4'(LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [3:0] cnt;
  logic       we_l;
  logic [A:0] addr_l;
  logic [P:0] data_l;
  logic       accept;
  logic       access;

  logic [P:0] mem [DEPTH];

  // A request is taken only from IDLE; the access fires once the wait counter has run out.
  always_comb begin
    accept = (state == IDLE) && req;
    access = (state == WAIT) && (cnt == 4'd0);
  end

  // Next-state decode: IDLE -> WAIT on request, WAIT -> DONE when the counter is spent, DONE always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request fields on acceptance so the inputs are free to change afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_l   <= we;
      addr_l <= addr;
      data_l <= data_in;
    end
  end

  // Wait counter, handshake flags and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 4'd0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      data_out <= '0;
    end else begin
      ack <= access;
      if (accept) begin
        cnt  <= LAT_LOAD;
        busy <= 1'b1;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (state == DONE) begin
        busy <= 1'b0;
      end
      if (access && !we_l) begin
        data_out <= mem[addr_l];
      end
    end
  end

  // Storage array: not cleared by reset, and a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && access && we_l) begin
      mem[addr_l] <= data_l;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder. Two instances are
// exercised side by side, one built with LAT=2 and one with LAT=0, against a
// behavioural model of a plain word array plus the last read value.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        req2, we2, ack2, busy2;
  logic [7:0]  addr2;
  logic [15:0] din2, dout2;

  logic        req0, we0, ack0, busy0;
  logic [7:0]  addr0;
  logic [15:0] din0, dout0;

  int tests  = 0;
  int failed = 0;

  // Model state, index 0 = LAT=2 instance, index 1 = LAT=0 instance.
  logic [15:0] mm      [2][256];
  bit          known   [2][256];
  logic [15:0] lastOut [2];

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] expOut;
  } vec_t;

  mem_responder #(.P(15), .A(7), .LAT(2)) dut (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2),
    .data_in(din2), .data_out(dout2), .ack(ack2), .busy(busy2)
  );

  mem_responder #(.P(15), .A(7), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0),
    .data_in(din0), .data_out(dout0), .ack(ack0), .busy(busy0)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] getAck(input bit fast);
    return fast ? {31'b0, ack0} : {31'b0, ack2};
  endfunction

  function automatic logic [31:0] getBusy(input bit fast);
    return fast ? {31'b0, busy0} : {31'b0, busy2};
  endfunction

  function automatic logic [31:0] getOut(input bit fast);
    return fast ? {16'b0, dout0} : {16'b0, dout2};
  endfunction

  // Reference behaviour: writes update the array, reads refresh the held output.
  function automatic logic [15:0] modelTxn(input bit fast, input bit w,
                                           input logic [7:0] a, input logic [15:0] d);
    if (w) begin
      mm[fast][a]    = d;
      known[fast][a] = 1'b1;
    end else begin
      lastOut[fast] = mm[fast][a];
    end
    return lastOut[fast];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input bit fast, input logic r, input logic w,
                       input logic [7:0] a, input logic [15:0] d);
    if (fast) begin
      req0 = r; we0 = w; addr0 = a; din0 = d;
    end else begin
      req2 = r; we2 = w; addr2 = a; din2 = d;
    end
  endtask

  // One complete transaction, starting and ending at a falling edge.
  task automatic applyStimulus(input bit fast, input bit w, input logic [7:0] a,
                               input logic [15:0] d, input logic [15:0] expOut,
                               input string tag);
    int lat;
    int n;
    lat = fast ? 0 : 2;
    n   = 0;
    drive(fast, 1'b1, w, a, d);
    @(posedge clk);
    @(negedge clk);
    drive(fast, 1'b0, 1'($urandom), 8'($urandom), 16'($urandom));
    checkOutput({tag, " busy after accept"}, getBusy(fast), 1);
    checkOutput({tag, " no early ack"}, getAck(fast), 0);
    while ((getAck(fast) !== 32'd1) && (n < 20)) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " ack latency"}, n, lat + 1);
    checkOutput({tag, " data_out at ack"}, getOut(fast), {16'b0, expOut});
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " ack one cycle"}, getAck(fast), 0);
    checkOutput({tag, " busy cleared"}, getBusy(fast), 0);
    checkOutput({tag, " data_out held"}, getOut(fast), {16'b0, expOut});
  endtask

  initial begin
    vec_t        vecs [7];
    int          acks;
    bit          fast;
    bit          w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] e;

    for (int i = 0; i < 2; i++) begin
      lastOut[i] = 16'h0000;
      for (int j = 0; j < 256; j++) begin
        known[i][j] = 1'b0;
        mm[i][j]    = 16'h0000;
      end
    end

    vecs[0] = '{w: 1'b1, a: 8'h05, d: 16'hBEEF, expOut: 16'h0000};
    vecs[1] = '{w: 1'b0, a: 8'h05, d: 16'h0000, expOut: 16'hBEEF};
    vecs[2] = '{w: 1'b1, a: 8'h00, d: 16'h1111, expOut: 16'hBEEF};
    vecs[3] = '{w: 1'b1, a: 8'hFF, d: 16'h2222, expOut: 16'hBEEF};
    vecs[4] = '{w: 1'b0, a: 8'h00, d: 16'h0000, expOut: 16'h1111};
    vecs[5] = '{w: 1'b0, a: 8'hFF, d: 16'h0000, expOut: 16'h2222};
    vecs[6] = '{w: 1'b0, a: 8'h05, d: 16'h0000, expOut: 16'hBEEF};

    // Reset then idle.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset ack", getAck(1'b0), 0);
    checkOutput("reset busy", getBusy(1'b0), 0);
    checkOutput("reset data_out", getOut(1'b0), 0);
    checkOutput("reset ack lat0", getAck(1'b1), 0);
    checkOutput("reset busy lat0", getBusy(1'b1), 0);
    checkOutput("reset data_out lat0", getOut(1'b1), 0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack2 || ack0 || busy2 || busy0) acks++;
    end
    checkOutput("idle no activity", acks, 0);

    // Table vectors: write/read and address boundaries on the LAT=2 instance.
    for (int i = 0; i < 7; i++) begin
      e = modelTxn(1'b0, vecs[i].w, vecs[i].a, vecs[i].d);
      applyStimulus(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].expOut,
                    $sformatf("vec%0d", i));
    end

    // Busy rejection: a write request raised during a read's wait is dropped.
    e = modelTxn(1'b0, 1'b1, 8'h10, 16'h5A5A);
    applyStimulus(1'b0, 1'b1, 8'h10, 16'h5A5A, e, "preload 10");
    drive(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h10, 16'h1234);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (ack2) acks++;
      @(posedge clk);
      @(negedge clk);
    end
    e = modelTxn(1'b0, 1'b0, 8'h10, 16'h0000);
    checkOutput("busy reject ack count", acks, 1);
    checkOutput("busy reject data_out", getOut(1'b0), {16'b0, e});
    checkOutput("busy reject idle", getBusy(1'b0), 0);
    e = modelTxn(1'b0, 1'b0, 8'h10, 16'h0000);
    applyStimulus(1'b0, 1'b0, 8'h10, 16'h0000, e, "busy reject reread");

    // Reset during a write's wait discards the write.
    e = modelTxn(1'b0, 1'b1, 8'hFF, 16'h0000);
    applyStimulus(1'b0, 1'b1, 8'hFF, 16'h0000, e, "preload FF");
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 16'hAAAA);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lastOut[0] = 16'h0000;
    lastOut[1] = 16'h0000;
    checkOutput("midreset busy", getBusy(1'b0), 0);
    checkOutput("midreset ack", getAck(1'b0), 0);
    checkOutput("midreset data_out", getOut(1'b0), 0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack2 || busy2) acks++;
    end
    checkOutput("midreset stays idle", acks, 0);
    e = modelTxn(1'b0, 1'b0, 8'hFF, 16'h0000);
    applyStimulus(1'b0, 1'b0, 8'hFF, 16'h0000, e, "midreset reread");

    // LAT=0 instance: back-to-back transactions every three edges.
    e = modelTxn(1'b1, 1'b1, 8'h33, 16'hC3C3);
    applyStimulus(1'b1, 1'b1, 8'h33, 16'hC3C3, e, "lat0 write");
    e = modelTxn(1'b1, 1'b0, 8'h33, 16'h0000);
    applyStimulus(1'b1, 1'b0, 8'h33, 16'h0000, e, "lat0 read");
    e = modelTxn(1'b1, 1'b1, 8'h34, 16'h3C3C);
    applyStimulus(1'b1, 1'b1, 8'h34, 16'h3C3C, e, "lat0 write2");
    e = modelTxn(1'b1, 1'b0, 8'h34, 16'h0000);
    applyStimulus(1'b1, 1'b0, 8'h34, 16'h0000, e, "lat0 read2");

    // LAT=0: a request held high through the edge leaving DONE is not taken.
    drive(1'b1, 1'b1, 1'b0, 8'h33, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("hold busy", getBusy(1'b1), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("hold ack", getAck(1'b1), 1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    e = modelTxn(1'b1, 1'b0, 8'h33, 16'h0000);
    checkOutput("hold not reaccepted", getBusy(1'b1), 0);
    checkOutput("hold data_out", getOut(1'b1), {16'b0, e});
    @(posedge clk);
    @(negedge clk);
    checkOutput("hold no second ack", getAck(1'b1), 0);

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 40; i++) begin
      fast = 1'($urandom_range(0, 1));
      a    = 8'($urandom);
      d    = 16'($urandom);
      w    = !known[fast][a] || ($urandom_range(0, 2) == 0);
      if (!w && ($urandom_range(0, 1) == 1)) begin
        for (int j = 0; j < 256; j++) begin
          if (known[fast][j]) a = 8'(j);
        end
      end
      e = modelTxn(fast, w, a, d);
      applyStimulus(fast, w, a, d, e, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
